// File: rtl/ripple_carry_adder.sv
// Registered ripple-carry adder: WIDTH full-adder cells chained from c_in, one-cycle latency.
// Optional macro RIPPLE_CARRY_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] sum_p0;
    logic             carry;
    logic             cout_p0;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    logic             msb_cin_p0;
`endif

    // Stage p0: combinational full-adder chain, carry propagating from bit 0 upward.
    always_comb begin
        sum_p0 = '0;
        carry  = c_in;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
        msb_cin_p0 = 1'b0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
            if (i == WIDTH - 1) begin
                msb_cin_p0 = carry;
            end
`endif
            sum_p0[i] = a[i] ^ b[i] ^ carry;
            carry     = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout_p0 = carry;
    end

    // Stage p1: output registers; reset overrides the sampled result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s     <= '0;
            c_out <= 1'b0;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            s     <= sum_p0;
            c_out <= cout_p0;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
            ovf   <= msb_cin_p0 ^ cout_p0;
`endif
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Bench for ripple_carry_adder (WIDTH=4): directed corner cases, exhaustive sweep and random
// traffic against an arithmetic reference model; covers ovf when RIPPLE_CARRY_ADDER_OVF_EN is set.
module tb_ripple_carry_adder;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf_obs;

    int checks;
    int failures;

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    logic ovf;
    assign ovf_obs = ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    ripple_carry_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .s     (s),
        .c_out (c_out)
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, c_out, s} from plain unsigned and signed integer arithmetic.
    function automatic logic [7:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                         input logic mc, input logic mrst);
        int          usum;
        int          ssum;
        int          sa;
        int          sb;
        logic        movf;
        logic [7:0]  r;
        if (mrst) return 8'h00;
        usum = int'(ma) + int'(mb) + int'(mc);
        sa   = (int'(ma) >= 8) ? int'(ma) - 16 : int'(ma);
        sb   = (int'(mb) >= 8) ? int'(mb) - 16 : int'(mb);
        ssum = sa + sb + int'(mc);
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
        movf = (ssum > 7) || (ssum < -8);
`else
        movf = 1'b0;
`endif
        r = {2'b00, movf, usum[4], usum[3:0]};
        return r;
    endfunction

    function automatic logic [7:0] observed();
        return {2'b00, ovf_obs, c_out, s};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] sa, input logic [3:0] sb,
                        input logic sc, input logic sr);
        a    = sa;
        b    = sb;
        c_in = sc;
        rst  = sr;
        @(posedge clk);
        #1;
        chk(tag, observed(), model(sa, sb, sc, sr));
    endtask

    initial begin
        logic [7:0] held;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        logic       rr;
        checks   = 0;
        failures = 0;
        a = '0; b = '0; c_in = 1'b0; rst = 1'b1;

        // Reset held for two edges with arbitrary inputs.
        step("rst_hold0", 4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
        step("rst_hold1", 4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
        chk("rst_s0", {3'b000, c_out, s}, 8'h00);

        // First cycle after release is already valid.
        step("first_valid", 4'b0010, 4'b0011, 1'b1, 1'b0);
        step("wrap", 4'b1111, 4'b0001, 1'b0, 1'b0);
        chk("wrap_exact", {3'b000, c_out, s}, 8'h10);
        step("max", 4'b1111, 4'b1111, 1'b1, 1'b0);
        chk("max_exact", {3'b000, c_out, s}, 8'h1F);

        // Result then reset: the in-flight sum is discarded.
        step("pre_rst", 4'b0101, 4'b0011, 1'b0, 1'b0);
        chk("pre_rst_exact", {3'b000, c_out, s}, 8'h08);
        step("mid_rst", 4'b0101, 4'b0011, 1'b0, 1'b1);
        chk("mid_rst_exact", {3'b000, c_out, s}, 8'h00);
        step("post_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
        step("ovf_pos", 4'b0111, 4'b0001, 1'b0, 1'b0);
        chk("ovf_pos_exact", observed(), 8'h28);
        step("ovf_neg", 4'b1000, 4'b1000, 1'b0, 1'b0);
        chk("ovf_neg_exact", observed(), 8'h30);
        step("ovf_none", 4'b1111, 4'b0001, 1'b0, 1'b0);
`endif

        // Exhaustive sweep, one operation per cycle.
        for (int i = 0; i < 512; i++) begin
            step("sweep", 4'(i >> 5), 4'(i >> 1), 1'(i), 1'b0);
        end

        // Random traffic with occasional resets and mid-cycle input changes.
        for (int i = 0; i < 300; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rc = 1'($urandom);
            rr = ($urandom_range(0, 15) == 0);
            step("rand", ra, rb, rc, rr);
            held = observed();
            a    = 4'($urandom);
            b    = 4'($urandom);
            c_in = 1'($urandom);
            #3;
            if (i % 10 == 0) chk("hold", observed(), held);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
